// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the instruction-fetch (IF) and
//            load/store (LS) requesters of a pipelined RV32 core. One access
//            is granted at a time. The granted request fields are registered
//            toward memory and held until mem_valid. The completion is
//            returned as a registered one-cycle pulse with read data. stall is
//            raised while an LS access is open.
// Option   : `define ARB_TIMEOUT_EN enables the busy-cycle watchdog. It
//            aborts an access after TIMEOUT_CYCLES busy cycles without
//            mem_valid.
// Ports    : clk        clock, rising edge
//            rst        synchronous reset, active-low
//            if_req     fetch request, held until if_valid
//            if_addr    fetch address
//            if_valid   one-cycle fetch completion pulse
//            if_rdata   fetched instruction, valid with if_valid
//            ls_req     load/store request, held until ls_valid
//            ls_we_re   1 = store, 0 = load
//            ls_mask    byte enables
//            ls_addr    data address
//            ls_wdata   store data
//            ls_valid   one-cycle load/store completion pulse
//            ls_rdata   load data, valid with ls_valid
//            mem_req    memory request, held until mem_valid
//            mem_we_re  memory write enable
//            mem_mask   memory byte enables
//            mem_addr   memory address
//            mem_wdata  memory write data
//            mem_rdata  memory read data, valid with mem_valid
//            mem_valid  memory completion, one cycle
//            stall      ls_req && !ls_valid
//            err        watchdog abort pulse (0 without ARB_TIMEOUT_EN)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_LS_BURST   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we_re,
  input  logic [3:0]  ls_mask,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        stall,
  output logic        err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_LS_BUSY = 2'd2;

  localparam int               CNT_W   = $clog2(MAX_LS_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LS_BURST);

  // Instruction returned on a watchdog abort of a fetch (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] ls_cnt;
  logic             grant_if;
  logic             grant_ls;
  logic             busy;
  logic             complete;
  logic             timeout;

  // Elaboration-time sanity check of the configuration.
  if (MAX_LS_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_port_arbiter: MAX_LS_BURST and TIMEOUT_CYCLES must be >= 1");
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_ls) begin
          state_nxt = ST_LS_BUSY;
        end else if (grant_if) begin
          state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY, ST_LS_BUSY: begin
        if (mem_valid || timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / grant logic
  // A grant is held off while a completion pulse is out. The requester that
  // just completed still shows its request in that cycle, so granting then
  // would issue a duplicate access.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == ST_IDLE && !if_valid && !ls_valid) begin
      if (if_req && (!ls_req || ls_cnt == CNT_MAX)) begin
        grant_if = 1'b1;
      end else if (ls_req) begin
        grant_ls = 1'b1;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign complete = busy && (mem_valid || timeout);
  assign stall    = ls_req && !ls_valid;

  // --------------------------------------------------------------------------
  // LS burst counter: counts LS grants taken while a fetch is waiting. The
  // fetch is forced through when the counter reaches MAX_LS_BURST.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      ls_cnt <= '0;
    end else if (!if_req || grant_if) begin
      ls_cnt <= '0;
    end else if (grant_ls && ls_cnt != CNT_MAX) begin
      ls_cnt <= ls_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Busy watchdog
  // --------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // to_cnt holds the number of busy cycles already elapsed. The abort
  // therefore fires at the end of the TIMEOUT_CYCLES-th busy cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!busy || mem_valid || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout = busy && !mem_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Memory-side request registers and requester-side response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we_re <= 1'b0;
      mem_mask  <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_valid  <= 1'b0;
      if_rdata  <= 32'h0;
      ls_valid  <= 1'b0;
      ls_rdata  <= 32'h0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we_re <= 1'b0;
        mem_mask  <= 4'hF;
        mem_addr  <= if_addr;
        mem_wdata <= 32'h0;
      end else if (grant_ls) begin
        mem_req   <= 1'b1;
        mem_we_re <= ls_we_re;
        mem_mask  <= ls_mask;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end else if (complete) begin
        mem_req <= 1'b0;
        if (state == ST_IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= timeout ? NOP_INSN : mem_rdata;
        end else begin
          // Stores and aborted accesses carry no read data.
          ls_valid <= 1'b1;
          ls_rdata <= (mem_we_re || timeout) ? 32'h0 : mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire
